// File: rtl/tx_buffer_if.sv
// tx_buffer_if: host write, tx_fsm bit-read and status signals of the transmit buffer
interface tx_buffer_if #(parameter int ADDR_WIDTH = 4);
  logic [7:0]          data_parallel;
  logic                data_parallel_wr_enable;
  logic                buffer_rd_enable;
  logic                buffer_data;
  logic                empty;
  logic                full;
  logic [ADDR_WIDTH:0] count;
  logic                overflow;
  logic                underflow;
  modport master (output data_parallel, data_parallel_wr_enable, buffer_rd_enable,
                  input buffer_data, empty, full, count, overflow, underflow);
  modport slave (input data_parallel, data_parallel_wr_enable, buffer_rd_enable,
                 output buffer_data, empty, full, count, overflow, underflow);
endinterface

// File: rtl/tx_buffer.sv
// tx_buffer: byte FIFO feeding an LSB-first bit serializer; ports clk, reset, bus (slave: write strobe/data in, read strobe in, bit/status out)
module tx_buffer #(
  parameter int NO_OF_DATA_BITS = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int ADDR_WIDTH      = 4
) (
  input logic        clk,
  input logic        reset,
  tx_buffer_if.slave bus
);
  localparam int BW = $clog2(NO_OF_DATA_BITS);
  logic [NO_OF_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_q, count_n;
  logic [BW-1:0]         bit_ptr;
  logic                  data_q, ovf_q, udf_q, empty, full, rd_ok, pop, wr_ok;
  assign empty = count_q == '0;
  assign full  = count_q == (ADDR_WIDTH+1)'(FIFO_DEPTH);
  assign rd_ok = bus.buffer_rd_enable && !empty;
  assign pop   = rd_ok && bit_ptr == BW'(NO_OF_DATA_BITS-1);
  // a pop frees the head slot on the same edge, so a write into a full FIFO is still taken
  assign wr_ok = bus.data_parallel_wr_enable && (!full || pop);
  always_comb
    count_n = (wr_ok && !pop) ? count_q + (ADDR_WIDTH+1)'(1) :
              (!wr_ok && pop) ? count_q - (ADDR_WIDTH+1)'(1) : count_q;
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= bus.data_parallel[NO_OF_DATA_BITS-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      bit_ptr <= '0;
      count_q <= '0;
      data_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ok ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
      bit_ptr <= pop ? '0 : rd_ok ? bit_ptr + BW'(1) : bit_ptr;
      data_q  <= rd_ok ? mem[rd_ptr][bit_ptr] : data_q;
      count_q <= count_n;
      ovf_q   <= bus.data_parallel_wr_enable && !wr_ok;
      udf_q   <= bus.buffer_rd_enable && empty;
    end
  end
  assign bus.buffer_data = data_q;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
endmodule

// File: tb/tb_tx_buffer.sv
// tb_tx_buffer: directed self-checking bench for tx_buffer (8-bit and 6-bit instances)
module tb_tx_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  tx_buffer_if #(.ADDR_WIDTH(4)) bus ();
  tx_buffer_if #(.ADDR_WIDTH(4)) bus6 ();
  tx_buffer #(.NO_OF_DATA_BITS(8), .FIFO_DEPTH(16), .ADDR_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  tx_buffer #(.NO_OF_DATA_BITS(6), .FIFO_DEPTH(16), .ADDR_WIDTH(4)) dut6 (.clk(clk), .reset(reset), .bus(bus6));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] b);
    bus.data_parallel = b;
    bus.data_parallel_wr_enable = 1'b1;
    tick();
    bus.data_parallel_wr_enable = 1'b0;
  endtask
  task automatic rd();
    bus.buffer_rd_enable = 1'b1;
    tick();
    bus.buffer_rd_enable = 1'b0;
  endtask
  task automatic rd_byte(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      rd();
      b[i] = bus.buffer_data;
    end
  endtask
  initial begin
    logic [7:0] b;
    logic [7:0] a5;
    bus.data_parallel = '0;
    bus.data_parallel_wr_enable = 1'b0;
    bus.buffer_rd_enable = 1'b0;
    bus6.data_parallel = '0;
    bus6.data_parallel_wr_enable = 1'b0;
    bus6.buffer_rd_enable = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_data", bus.buffer_data, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_udf", bus.underflow, 0);
    wr(8'hA5);
    chk("a5_count", bus.count, 1);
    chk("a5_empty", bus.empty, 0);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      rd();
      chk($sformatf("a5_bit%0d", i), bus.buffer_data, a5[i]);
      if (i < 7) chk($sformatf("a5_notempty%0d", i), bus.empty, 0);
      tick();
      tick();
      chk($sformatf("a5_hold%0d", i), bus.buffer_data, a5[i]);
    end
    chk("a5_empty_after", bus.empty, 1);
    chk("a5_count_after", bus.count, 0);
    rd();
    chk("udf_pulse", bus.underflow, 1);
    chk("udf_data_held", bus.buffer_data, 1);
    chk("udf_count", bus.count, 0);
    tick();
    chk("udf_clear", bus.underflow, 0);
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 16);
    chk("fill_no_ovf", bus.overflow, 0);
    wr(8'hFF);
    chk("ovf_pulse", bus.overflow, 1);
    chk("ovf_count", bus.count, 16);
    tick();
    chk("ovf_clear", bus.overflow, 0);
    for (int i = 0; i < 7; i++) begin
      rd();
      b[i] = bus.buffer_data;
    end
    bus.data_parallel = 8'h3C;
    bus.data_parallel_wr_enable = 1'b1;
    bus.buffer_rd_enable = 1'b1;
    tick();
    bus.data_parallel_wr_enable = 1'b0;
    bus.buffer_rd_enable = 1'b0;
    b[7] = bus.buffer_data;
    chk("pw_byte0", b, 8'h00);
    chk("pw_no_ovf", bus.overflow, 0);
    chk("pw_count", bus.count, 16);
    chk("pw_full", bus.full, 1);
    for (int i = 1; i < 16; i++) begin
      rd_byte(b);
      chk($sformatf("drain_byte%0d", i), b, 8'(i));
    end
    rd_byte(b);
    chk("drain_3c", b, 8'h3C);
    chk("drain_empty", bus.empty, 1);
    chk("drain_count", bus.count, 0);
    wr(8'h5A);
    for (int i = 0; i < 4; i++) rd();
    chk("mid_data", bus.buffer_data, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_empty", bus.empty, 1);
    chk("mrst_count", bus.count, 0);
    chk("mrst_data", bus.buffer_data, 0);
    for (int i = 0; i < 8; i++) begin
      rd();
      chk($sformatf("mrst_udf%0d", i), bus.underflow, 1);
      chk($sformatf("mrst_bit%0d", i), bus.buffer_data, 0);
    end
    chk("mrst_empty_end", bus.empty, 1);
    bus6.data_parallel_wr_enable = 1'b1;
    bus6.data_parallel = 8'hFF;
    tick();
    bus6.data_parallel = 8'h01;
    tick();
    bus6.data_parallel_wr_enable = 1'b0;
    chk("w6_count", bus6.count, 2);
    for (int i = 0; i < 12; i++) begin
      bus6.buffer_rd_enable = 1'b1;
      tick();
      bus6.buffer_rd_enable = 1'b0;
      chk($sformatf("w6_bit%0d", i), bus6.buffer_data, (i < 6 || i == 6) ? 1 : 0);
    end
    chk("w6_empty", bus6.empty, 1);
    chk("w6_no_udf", bus6.underflow, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
